// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and default width for the sequential ALU.
package alu_pkg;

    localparam int ALU_DATA_W = 32;

    localparam logic [3:0] OP_SLL  = 4'b0000;
    localparam logic [3:0] OP_SRL  = 4'b0010;
    localparam logic [3:0] OP_SRA  = 4'b0011;
    localparam logic [3:0] OP_SLT  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_ADD  = 4'b1000;
    localparam logic [3:0] OP_SUB  = 4'b1010;
    localparam logic [3:0] OP_AND  = 4'b1100;
    localparam logic [3:0] OP_OR   = 4'b1101;
    localparam logic [3:0] OP_XOR  = 4'b1110;
    localparam logic [3:0] OP_MUL  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, DATA_W cycles per product.
// done pulses for one cycle, with product holding the low DATA_W bits.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] multiplicand;
    logic [DATA_W-1:0] multiplier;
    logic [CNT_W-1:0]  cnt;
    logic              running;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc          <= '0;
            multiplicand <= '0;
            multiplier   <= '0;
            cnt          <= '0;
            running      <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                acc          <= '0;
                multiplicand <= a;
                multiplier   <= b;
                cnt          <= CNT_W'(DATA_W);
                running      <= 1'b1;
            end else if (running) begin
                acc          <= acc + (multiplier[0] ? multiplicand : '0);
                multiplicand <= multiplicand << 1;
                multiplier   <= multiplier >> 1;
                cnt          <= cnt - 1'b1;
                // Last iteration: acc holds the full product after this edge.
                if (cnt == CNT_W'(1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

    assign product = acc;

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle ops plus optional iterative MUL.
// Build option ALU_MUL_EN enables the MUL state and the alu_mul_seq datapath.
module alu_seq
    import alu_pkg::*;
#(
    parameter int DATA_W  = ALU_DATA_W,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] inp1,
    input  logic [DATA_W-1:0] inp2,
    input  logic [3:0]        ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out1,
    output logic              zero
);

    state_t            state_q;
    state_t            state_d;
    logic              load_alu;
    logic              is_mul;
    logic [DATA_W-1:0] alu_res;
    logic [SHAMT_W-1:0] shamt;

    assign shamt = inp2[SHAMT_W-1:0];

    always_comb begin
        alu_res = '0;
        case (ctrl)
            OP_ADD:  alu_res = inp1 + inp2;
            OP_SUB:  alu_res = inp1 - inp2;
            OP_AND:  alu_res = inp1 & inp2;
            OP_OR:   alu_res = inp1 | inp2;
            OP_XOR:  alu_res = inp1 ^ inp2;
            OP_SLL:  alu_res = inp1 << shamt;
            OP_SRL:  alu_res = inp1 >> shamt;
            OP_SRA:  alu_res = DATA_W'($signed(inp1) >>> shamt);
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(inp1) < $signed(inp2))};
            OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (inp1 < inp2)};
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_MUL_EN
    logic              mul_start;
    logic              mul_done;
    logic              load_mul;
    logic [DATA_W-1:0] mul_product;

    assign is_mul    = (ctrl == OP_MUL);
    assign mul_start = in_valid && in_ready && is_mul;

    alu_mul_seq #(
        .DATA_W(DATA_W)
    ) u_mul (
        .clk    (clk),
        .rst    (rst),
        .start  (mul_start),
        .a      (inp1),
        .b      (inp2),
        .done   (mul_done),
        .product(mul_product)
    );
`else
    assign is_mul = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // In DONE, in_ready follows out_ready so a new op can replace the result being consumed.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        load_alu = 1'b0;
`ifdef ALU_MUL_EN
        load_mul = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d  = is_mul ? MUL : DONE;
                    load_alu = !is_mul;
                end
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        state_d  = is_mul ? MUL : DONE;
                        load_alu = !is_mul;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
`ifdef ALU_MUL_EN
            MUL: begin
                if (mul_done) begin
                    state_d  = DONE;
                    load_mul = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out1 <= '0;
            zero <= 1'b1;
        end else if (load_alu) begin
            out1 <= alu_res;
            zero <= (alu_res == '0);
`ifdef ALU_MUL_EN
        end else if (load_mul) begin
            out1 <= mul_product;
            zero <= (mul_product == '0);
`endif
        end
    end

    assign out_valid = (state_q == DONE);

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (32-bit instance plus a 16-bit instance for width scaling).
// MUL checks run when ALU_MUL_EN is defined; otherwise 1111 is checked as illegal.
module tb_alu_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] inp1;
    logic [31:0] inp2;
    logic [3:0]  ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out1;
    logic        zero;

    logic        in_valid16;
    logic        in_ready16;
    logic [15:0] inp1_16;
    logic [15:0] inp2_16;
    logic [3:0]  ctrl16;
    logic        out_valid16;
    logic        out_ready16;
    logic [15:0] out1_16;
    logic        zero16;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] q[$];

    always #5 clk = ~clk;

    alu_seq #(.DATA_W(32)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .inp1(inp1), .inp2(inp2), .ctrl(ctrl), .out_valid(out_valid),
        .out_ready(out_ready), .out1(out1), .zero(zero)
    );

    alu_seq #(.DATA_W(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .inp1(inp1_16), .inp2(inp2_16), .ctrl(ctrl16), .out_valid(out_valid16),
        .out_ready(out_ready16), .out1(out1_16), .zero(zero16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLL:  return a << sh;
            OP_SRL:  return a >> sh;
            OP_SRA:  return 32'($signed(a) >>> sh);
            OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
`ifdef ALU_MUL_EN
            OP_MUL:  return a * b;
`endif
            default: return 32'd0;
        endcase
    endfunction

    // Pop on output handshake before pushing a same-cycle input handshake.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("spurious_out", 32'd1, 32'd0);
                end else begin
                    logic [31:0] e;
                    e = q.pop_front();
                    check("out1", out1, e);
                    check("zero", {31'd0, zero}, {31'd0, (e == 32'd0)});
                end
            end
            if (in_valid && in_ready)
                q.push_back(model(ctrl, inp1, inp2));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        ctrl = op; inp1 = a; inp2 = b; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_lat1(input string tag, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b);
        send(op, a, b);
        @(negedge clk);
        check(tag, {31'd0, out_valid}, 32'd1);
        idle(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        inp1 = '0; inp2 = '0; ctrl = '0;
        in_valid16 = 1'b0; out_ready16 = 1'b1; inp1_16 = '0; inp2_16 = '0; ctrl16 = '0;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out1", out1, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd1);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        idle(1);

        send_lat1("lat_add", OP_ADD, 32'hFFFF_FFFF, 32'h1);
        send_lat1("lat_sub", OP_SUB, 32'd5, 32'd7);
        send_lat1("lat_sll", OP_SLL, 32'h8000_0000, 32'h24);
        send_lat1("lat_srl", OP_SRL, 32'h8000_0000, 32'h24);
        send_lat1("lat_sra", OP_SRA, 32'h8000_0000, 32'h24);
        send_lat1("lat_slt", OP_SLT, 32'hFFFF_FFFF, 32'd1);
        send_lat1("lat_sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1);
        send_lat1("lat_xor", OP_XOR, 32'hA5A5_0F0F, 32'h0FF0_FFFF);
        send_lat1("lat_or", OP_OR, 32'h1200_0000, 32'h0000_0034);
        send_lat1("lat_ill", 4'b0111, 32'h1234, 32'h5678);
`ifndef ALU_MUL_EN
        send_lat1("lat_ill_mul", OP_MUL, 32'h0000_FFFF, 32'h0001_0001);
`endif

        // back-to-back: issue consecutive ops without idle cycles
        for (int i = 0; i < 6; i++)
            send(OP_ADD, $urandom, $urandom);
        idle(2);

        out_ready = 1'b0;
        send(OP_ADD, 32'd3, 32'd4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_out1", out1, 32'd7);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        idle(1);
        out_ready = 1'b1;
        send(OP_AND, 32'hF0, 32'h3C);
        @(negedge clk);
        check("no_bubble", {31'd0, out_valid}, 32'd1);
        idle(2);

`ifdef ALU_MUL_EN
        send(OP_MUL, 32'h0000_FFFF, 32'h0001_0001);
        inp1 = 32'hDEAD_BEEF; inp2 = 32'h1234_5678; ctrl = OP_SUB;
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            n++;
            #1;
            if (out_valid) break;
            check("mul_in_ready", {31'd0, in_ready}, 32'd0);
        end
        check("mul_latency", n, 32'd33);
        idle(2);

        send(OP_MUL, 32'd3, 32'd5);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        idle(1);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_out1", out1, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        send_lat1("lat_post_abort", OP_ADD, 32'd1, 32'd1);
        send(OP_MUL, 32'd12345, 32'd678);
        idle(40);
`endif

        in_valid16 = 1'b1; ctrl16 = OP_ADD; inp1_16 = 16'hFFFF; inp2_16 = 16'h0001;
        @(negedge clk);
        check("w16_in_ready", {31'd0, in_ready16}, 32'd1);
        idle(1);
        in_valid16 = 1'b0;
        @(negedge clk);
        check("w16_out_valid", {31'd0, out_valid16}, 32'd1);
        check("w16_out1", {16'd0, out1_16}, 32'd0);
        check("w16_zero", {31'd0, zero16}, 32'd1);
        idle(1);

        idle(3);
        check("drain", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
